gem_tmb_fiber_rx_check: RTL and testbench

- Loopback receive-side checker for the GEM/TMB fiber link, sitting directly downstream of the GTP receive datapath on the same tile used by the TMB fiber transmitter.
- Consumes the 32-bit/80 MHz word stream and classifies each word as idle, data or separator.
- Acquires frame lock, rebuilds each 48-bit payload, flags latency markers and keeps error and frame counters for production-test readout.

---
 rtl/gem_tmb_fiber_rx_check.sv | 218 +++++++++++++++++++++
 tb/tb_gem_tmb_fiber_rx_check.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gem_tmb_fiber_rx_check.sv
// Loopback receive checker for the GEM/TMB fiber link.
// Classifies each 32-bit word from the GTP receiver, acquires DATA/SEP frame
// lock, rebuilds 48-bit payloads, flags latency markers and keeps counters
// for production-test readout.
module gem_tmb_fiber_rx_check #(
  parameter int LOCK_FRAMES = 4,
  parameter int UNLOCK_ERRS = 4
) (
  input  logic        TMB_CLK80,
  input  logic        TMB_TXRESETDONE0,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_isk,
  input  logic [3:0]  rx_disperr,
  input  logic [3:0]  rx_notintable,
  input  logic        clr_cnt,
  output logic [47:0] out_data,
  output logic        out_valid,
  output logic        out_marker,
  output logic        locked,
  output logic        link_idle,
  output logic [31:0] frame_cnt,
  output logic [15:0] frame_err_cnt,
  output logic [15:0] code_err_cnt,
  output logic [15:0] marker_interval
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0]  LOCK_N   = LOCK_FRAMES[3:0];
  localparam logic [3:0]  UNLOCK_N = UNLOCK_ERRS[3:0];
  localparam logic [15:0] SAT_MAX  = 16'hFFFF;

  state_t      state, state_nxt;
  logic        phase, phase_nxt;          // 0 = A slot (DATA), 1 = B slot (SEP)
  logic [3:0]  good_run, good_run_nxt;
  logic [3:0]  bad_run, bad_run_nxt;
  logic [31:0] a_reg;
  logic        a_bad;
  logic        capture_a;
  logic        good_frame;
  logic        bad_frame;
  logic        enter_lock;
  logic [15:0] mark_cnt;
  logic        mark_seen;

  logic is_code, is_idle, is_sep, is_data, sep_marker;

  // Word classification; a code error masks every other class
  always_comb begin
    is_code    = (|rx_disperr) | (|rx_notintable);
    is_idle    = !is_code && (rx_data == 32'h50BC50BC) && (rx_isk == 4'b0101);
    is_sep     = !is_code && (rx_isk == 4'b0001) &&
                 ((rx_data[15:0] == 16'h50BC) || (rx_data[15:0] == 16'h50FC));
    is_data    = !is_code && (rx_isk == 4'b0000);
    sep_marker = (rx_data[15:0] == 16'h50FC);
  end

  // Lock FSM state register
  always_ff @(posedge TMB_CLK80 or negedge TMB_TXRESETDONE0) begin
    if (!TMB_TXRESETDONE0) begin
      state    <= SEARCH;
      phase    <= 1'b0;
      good_run <= 4'd0;
      bad_run  <= 4'd0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      good_run <= good_run_nxt;
      bad_run  <= bad_run_nxt;
    end
  end

  // Lock FSM next state, slot tracking and frame verdicts
  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    good_run_nxt = good_run;
    bad_run_nxt  = bad_run;
    capture_a    = 1'b0;
    good_frame   = 1'b0;
    bad_frame    = 1'b0;
    enter_lock   = 1'b0;
    if (is_idle) begin
      state_nxt    = SEARCH;
      phase_nxt    = 1'b0;
      good_run_nxt = 4'd0;
      bad_run_nxt  = 4'd0;
    end else begin
      case (state)
        SEARCH: begin
          if (!phase) begin
            if (is_data) begin
              capture_a = 1'b1;
              phase_nxt = 1'b1;
            end
          end else if (is_sep) begin
            phase_nxt    = 1'b0;
            good_run_nxt = good_run + 4'd1;
            if (good_run + 4'd1 == LOCK_N) begin
              state_nxt   = LOCKED;
              bad_run_nxt = 4'd0;
              enter_lock  = 1'b1;
            end
          end else begin
            good_run_nxt = 4'd0;
            if (is_data) begin
              capture_a = 1'b1;
              phase_nxt = 1'b1;
            end else begin
              phase_nxt = 1'b0;
            end
          end
        end
        LOCKED: begin
          if (!phase) begin
            capture_a = 1'b1;
            phase_nxt = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            if (a_bad || !is_sep) begin
              bad_frame   = 1'b1;
              bad_run_nxt = bad_run + 4'd1;
              if (bad_run + 4'd1 == UNLOCK_N) begin
                state_nxt    = SEARCH;
                good_run_nxt = 4'd0;
              end
            end else begin
              good_frame  = 1'b1;
              bad_run_nxt = 4'd0;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // A-slot capture, payload rebuild and status outputs
  always_ff @(posedge TMB_CLK80 or negedge TMB_TXRESETDONE0) begin
    if (!TMB_TXRESETDONE0) begin
      a_reg      <= 32'd0;
      a_bad      <= 1'b0;
      out_data   <= 48'd0;
      out_valid  <= 1'b0;
      out_marker <= 1'b0;
      locked     <= 1'b0;
      link_idle  <= 1'b0;
    end else begin
      if (capture_a) begin
        a_reg <= rx_data;
        a_bad <= !is_data;
      end
      out_valid  <= good_frame;
      out_marker <= good_frame && sep_marker;
      if (good_frame) begin
        out_data <= {a_reg, rx_data[31:16]};
      end
      locked    <= (state_nxt == LOCKED);
      link_idle <= is_idle;
    end
  end

  // Frame, frame-error and code-error counters; clear beats increment
  always_ff @(posedge TMB_CLK80 or negedge TMB_TXRESETDONE0) begin
    if (!TMB_TXRESETDONE0) begin
      frame_cnt     <= 32'd0;
      frame_err_cnt <= 16'd0;
      code_err_cnt  <= 16'd0;
    end else if (clr_cnt) begin
      frame_cnt     <= 32'd0;
      frame_err_cnt <= 16'd0;
      code_err_cnt  <= 16'd0;
    end else begin
      if (good_frame) begin
        frame_cnt <= frame_cnt + 32'd1;
      end
      if (bad_frame && (frame_err_cnt != SAT_MAX)) begin
        frame_err_cnt <= frame_err_cnt + 16'd1;
      end
      if (is_code && (code_err_cnt != SAT_MAX)) begin
        code_err_cnt <= code_err_cnt + 16'd1;
      end
    end
  end

  // Frames-since-marker tracking, restarted at every lock acquisition
  always_ff @(posedge TMB_CLK80 or negedge TMB_TXRESETDONE0) begin
    if (!TMB_TXRESETDONE0) begin
      mark_cnt  <= 16'd0;
      mark_seen <= 1'b0;
    end else if (enter_lock) begin
      mark_cnt  <= 16'd0;
      mark_seen <= 1'b0;
    end else if (good_frame) begin
      if (sep_marker) begin
        mark_cnt  <= 16'd1;
        mark_seen <= 1'b1;
      end else if (mark_cnt != SAT_MAX) begin
        mark_cnt <= mark_cnt + 16'd1;
      end
    end
  end

  // Marker interval latch; only meaningful once two markers seen since lock
  always_ff @(posedge TMB_CLK80 or negedge TMB_TXRESETDONE0) begin
    if (!TMB_TXRESETDONE0) begin
      marker_interval <= 16'd0;
    end else if (clr_cnt) begin
      marker_interval <= 16'd0;
    end else if (good_frame && sep_marker && mark_seen) begin
      marker_interval <= mark_cnt;
    end
  end

endmodule

// File: tb/tb_gem_tmb_fiber_rx_check.sv
// Self-checking bench for gem_tmb_fiber_rx_check: lock table, then
// hand-written marker, unlock, code-error, saturation and reset sequences.
module tb_gem_tmb_fiber_rx_check;

  logic        TMB_CLK80;
  logic        TMB_TXRESETDONE0;
  logic [31:0] rx_data;
  logic [3:0]  rx_isk;
  logic [3:0]  rx_disperr;
  logic [3:0]  rx_notintable;
  logic        clr_cnt;
  logic [47:0] out_data;
  logic        out_valid;
  logic        out_marker;
  logic        locked;
  logic        link_idle;
  logic [31:0] frame_cnt;
  logic [15:0] frame_err_cnt;
  logic [15:0] code_err_cnt;
  logic [15:0] marker_interval;

  int total = 0;
  int bad   = 0;
  logic [48:0] sb_q[$];

  localparam logic [31:0] IDLE_W = 32'h50BC50BC;
  localparam logic [31:0] DATA_W = 32'h11223344;
  localparam logic [31:0] SEP_W  = 32'h556650BC;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        exp_valid;
    logic [47:0] exp_data;
    logic        exp_locked;
    logic        exp_idle;
  } vec_t;

  vec_t vecs[20];

  gem_tmb_fiber_rx_check #(.LOCK_FRAMES(4), .UNLOCK_ERRS(4)) dut (
    .TMB_CLK80       (TMB_CLK80),
    .TMB_TXRESETDONE0(TMB_TXRESETDONE0),
    .rx_data         (rx_data),
    .rx_isk          (rx_isk),
    .rx_disperr      (rx_disperr),
    .rx_notintable   (rx_notintable),
    .clr_cnt         (clr_cnt),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_marker      (out_marker),
    .locked          (locked),
    .link_idle       (link_idle),
    .frame_cnt       (frame_cnt),
    .frame_err_cnt   (frame_err_cnt),
    .code_err_cnt    (code_err_cnt),
    .marker_interval (marker_interval)
  );

  // 80 MHz clock (12.5 ns rounded to 12 ns)
  initial begin
    TMB_CLK80 = 1'b0;
    forever #6 TMB_CLK80 = ~TMB_CLK80;
  end

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] d, input logic [3:0] k,
                                input logic [3:0] de, input logic [3:0] ni,
                                input logic clr, input logic expv,
                                input logic [47:0] expd, input logic expm);
    logic [48:0] e;
    @(negedge TMB_CLK80);
    rx_data       = d;
    rx_isk        = k;
    rx_disperr    = de;
    rx_notintable = ni;
    clr_cnt       = clr;
    if (expv) sb_q.push_back({expm, expd});
    @(posedge TMB_CLK80);
    #1;
    clr_cnt = 1'b0;
    check_output("out_valid", {63'd0, out_valid}, {63'd0, expv});
    if (out_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_output("out_data", {16'd0, out_data}, {16'd0, e[47:0]});
      check_output("out_marker", {63'd0, out_marker}, {63'd0, e[48]});
    end
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] sep, input logic expv);
    apply_stimulus(a, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 48'd0, 1'b0);
    apply_stimulus(sep, 4'b0001, 4'b0000, 4'b0000, 1'b0, expv,
                   {a, sep[31:16]}, sep[15:0] == 16'h50FC);
  endtask

  task automatic send_bad_frame(input logic [31:0] a, input logic clr);
    apply_stimulus(a, 4'b0000, 4'b0000, 4'b0000, clr, 1'b0, 48'd0, 1'b0);
    apply_stimulus(a + 32'd1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 48'd0, 1'b0);
  endtask

  task automatic check_locked(input string name, input logic want);
    check_output(name, {63'd0, locked}, {63'd0, want});
  endtask

  initial begin
    TMB_TXRESETDONE0 = 1'b0;
    rx_data       = IDLE_W;
    rx_isk        = 4'b0101;
    rx_disperr    = 4'b0000;
    rx_notintable = 4'b0000;
    clr_cnt       = 1'b0;

    // Lock-acquisition table: 10 idles, then 5 DATA/SEP frames
    for (int i = 0; i < 10; i++)
      vecs[i] = '{IDLE_W, 4'b0101, 1'b0, 48'd0, 1'b0, 1'b1};
    for (int f = 0; f < 5; f++) begin
      vecs[10 + 2*f]     = '{DATA_W, 4'b0000, 1'b0, 48'd0, (f >= 4), 1'b0};
      vecs[10 + 2*f + 1] = '{SEP_W, 4'b0001, (f == 4), 48'h112233445566, (f >= 3), 1'b0};
    end

    repeat (3) @(posedge TMB_CLK80);
    #1;
    check_output("rst_locked", {63'd0, locked}, 64'd0);
    check_output("rst_idle", {63'd0, link_idle}, 64'd0);
    check_output("rst_valid", {63'd0, out_valid}, 64'd0);
    check_output("rst_data", {16'd0, out_data}, 64'd0);
    check_output("rst_frame_cnt", {32'd0, frame_cnt}, 64'd0);
    check_output("rst_code_err", {48'd0, code_err_cnt}, 64'd0);
    @(negedge TMB_CLK80);
    TMB_TXRESETDONE0 = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply_stimulus(vecs[i].d, vecs[i].k, 4'b0000, 4'b0000, 1'b0,
                     vecs[i].exp_valid, vecs[i].exp_data, 1'b0);
      check_output($sformatf("vec%0d_locked", i), {63'd0, locked}, {63'd0, vecs[i].exp_locked});
      check_output($sformatf("vec%0d_idle", i), {63'd0, link_idle}, {63'd0, vecs[i].exp_idle});
    end
    check_output("lock_frame_cnt", {32'd0, frame_cnt}, 64'd1);

    $display("[TB] marker interval sequence");
    send_frame(32'hCAFE0000, 32'h000050FC, 1'b1);
    check_output("mi_first", {48'd0, marker_interval}, 64'd0);
    for (int i = 0; i < 127; i++) send_frame(32'hA0000000 + i, SEP_W, 1'b1);
    send_frame(32'hCAFE0001, 32'h123450FC, 1'b1);
    check_output("mi_second", {48'd0, marker_interval}, 64'd128);
    check_output("mi_frame_cnt", {32'd0, frame_cnt}, 64'd130);

    $display("[TB] error unlock sequence");
    apply_stimulus(DATA_W, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 48'd0, 1'b0);
    apply_stimulus(SEP_W, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, 48'h112233445566, 1'b0);
    check_output("clr_frame_cnt", {32'd0, frame_cnt}, 64'd1);
    check_output("clr_mi", {48'd0, marker_interval}, 64'd0);
    for (int i = 0; i < 3; i++) send_bad_frame(32'h0B000000 + i, 1'b0);
    check_locked("three_bad_locked", 1'b1);
    check_output("three_bad_errs", {48'd0, frame_err_cnt}, 64'd3);
    send_frame(32'h76543210, SEP_W, 1'b1);
    send_bad_frame(32'h0C000000, 1'b1);
    for (int i = 1; i < 3; i++) send_bad_frame(32'h0C000000 + i, 1'b0);
    check_locked("bad_run_cleared", 1'b1);
    send_bad_frame(32'h0C000003, 1'b0);
    check_locked("fourth_bad_unlock", 1'b0);
    check_output("unlock_errs", {48'd0, frame_err_cnt}, 64'd4);

    $display("[TB] code error sequence");
    apply_stimulus(DATA_W, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 48'd0, 1'b0);
    apply_stimulus(SEP_W, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 48'd0, 1'b0);
    for (int i = 0; i < 2; i++) send_frame(DATA_W, SEP_W, 1'b0);
    check_locked("search_not_yet", 1'b0);
    send_frame(DATA_W, SEP_W, 1'b0);
    check_locked("relock", 1'b1);
    apply_stimulus(32'h01010101, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0, 48'd0, 1'b0);
    apply_stimulus(SEP_W, 4'b0001, 4'b0010, 4'b0000, 1'b0, 1'b0, 48'd0, 1'b0);
    apply_stimulus(32'h02020202, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0, 48'd0, 1'b0);
    apply_stimulus(SEP_W, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 48'd0, 1'b0);
    check_output("code_errs", {48'd0, code_err_cnt}, 64'd3);
    check_output("code_frame_errs", {48'd0, frame_err_cnt}, 64'd2);
    check_locked("code_still_locked", 1'b1);
    send_frame(32'hDEADBEEF, 32'hFEED50BC, 1'b1);
    apply_stimulus(DATA_W, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 48'd0, 1'b0);
    apply_stimulus(DATA_W, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 48'd0, 1'b0);
    check_output("clr_win_ferr", {48'd0, frame_err_cnt}, 64'd0);
    check_output("clr_win_cerr", {48'd0, code_err_cnt}, 64'd0);
    check_output("clr_win_fcnt", {32'd0, frame_cnt}, 64'd0);
    check_locked("clr_keeps_lock", 1'b1);

    $display("[TB] code error saturation");
    @(negedge TMB_CLK80);
    rx_data       = 32'h0;
    rx_isk        = 4'b0000;
    rx_notintable = 4'b1111;
    repeat (65540) @(posedge TMB_CLK80);
    #1;
    check_output("code_sat", {48'd0, code_err_cnt}, 64'hFFFF);
    check_locked("code_sat_unlock", 1'b0);
    rx_notintable = 4'b0000;

    $display("[TB] reset mid-frame");
    apply_stimulus(IDLE_W, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, 48'd0, 1'b0);
    for (int i = 0; i < 4; i++) send_frame(DATA_W, SEP_W, 1'b0);
    send_frame(32'h99887766, SEP_W, 1'b1);
    check_locked("pre_reset_locked", 1'b1);
    apply_stimulus(32'h13572468, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 48'd0, 1'b0);
    @(negedge TMB_CLK80);
    TMB_TXRESETDONE0 = 1'b0;
    #1;
    check_output("async_locked", {63'd0, locked}, 64'd0);
    check_output("async_data", {16'd0, out_data}, 64'd0);
    check_output("async_fcnt", {32'd0, frame_cnt}, 64'd0);
    check_output("async_cerr", {48'd0, code_err_cnt}, 64'd0);
    check_output("async_mi", {48'd0, marker_interval}, 64'd0);
    repeat (2) @(posedge TMB_CLK80);
    @(negedge TMB_CLK80);
    rx_data = SEP_W;
    rx_isk  = 4'b0001;
    TMB_TXRESETDONE0 = 1'b1;
    apply_stimulus(SEP_W, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 48'd0, 1'b0);
    for (int i = 0; i < 3; i++) send_frame(DATA_W, SEP_W, 1'b0);
    check_locked("relock_three", 1'b0);
    send_frame(DATA_W, SEP_W, 1'b0);
    check_locked("relock_four", 1'b1);
    send_frame(32'h24681357, 32'hABCD50BC, 1'b1);

    check_output("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
